// File: rtl/tt_um_accelshark_psg_pkg.sv
// Shared constants and types for the SharkPSG channels: register map,
// control bit positions and default widths.
package tt_um_accelshark_psg_pkg;

  localparam int PSG_PERIOD_W = 12;
  localparam int PSG_VOL_W    = 4;

  localparam logic [1:0] PSG_ADDR_PERIOD_LO = 2'd0;
  localparam logic [1:0] PSG_ADDR_PERIOD_HI = 2'd1;
  localparam logic [1:0] PSG_ADDR_VOLUME    = 2'd2;
  localparam logic [1:0] PSG_ADDR_CTRL      = 2'd3;

  localparam int PSG_CTRL_EN_BIT      = 0;
  localparam int PSG_CTRL_RESTART_BIT = 1;

  // The state encoding is the CTRL enable bit itself.
  typedef enum logic {
    PSG_IDLE = 1'b0,
    PSG_RUN  = 1'b1
  } psg_state_e;

endpackage

// File: rtl/tt_um_accelshark_psg_tick.sv
// Rising-edge detector on the divider's half-rate toggle, producing a
// single-clk tick enable in the clk domain. Shared by all PSG channels.
module tt_um_accelshark_psg_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clk_div,
  input  logic i_ena,
  output logic o_tick
);

  logic r_clk_div_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; resetting to 1 keeps a high clk_div out of reset
  // from producing a spurious first tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_div_q <= 1'b1;
    end else begin
      r_clk_div_q <= i_clk_div;
    end
  end

  assign o_tick = i_ena & i_clk_div & ~r_clk_div_q;

endmodule

// File: rtl/tt_um_accelshark_psg_tone.sv
// SharkPSG square-wave tone channel: byte-wide register file, double-buffered
// period, tick-driven half-period down-counter and volume-gated level output.
module tt_um_accelshark_psg_tone
  import tt_um_accelshark_psg_pkg::*;
#(
  parameter int PERIOD_W = PSG_PERIOD_W,
  parameter int VOL_W    = PSG_VOL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clk_div,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  output logic             tone_out,
  output logic [VOL_W-1:0] level,
  output logic             wrap
);

  logic w_tick;

  tt_um_accelshark_psg_tick u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clk_div (clk_div),
    .i_ena     (ena),
    .o_tick    (w_tick)
  );

  logic w_wr_lo, w_wr_hi, w_wr_vol, w_wr_ctrl;

  assign w_wr_lo   = wr_en && (wr_addr == PSG_ADDR_PERIOD_LO);
  assign w_wr_hi   = wr_en && (wr_addr == PSG_ADDR_PERIOD_HI);
  assign w_wr_vol  = wr_en && (wr_addr == PSG_ADDR_VOLUME);
  assign w_wr_ctrl = wr_en && (wr_addr == PSG_ADDR_CTRL);

  logic [PERIOD_W-1:0] r_shadow_period;
  logic [PERIOD_W-1:0] r_active_period;
  logic [PERIOD_W-1:0] r_counter;
  logic [VOL_W-1:0]    r_volume;
  logic                r_phase;
  logic                r_restart_pend;
  logic                r_wrap;
  psg_state_e          r_state, w_state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_period <= '0;
      r_volume        <= '0;
    end else begin
      if (w_wr_lo)  r_shadow_period[7:0]          <= wr_data;
      if (w_wr_hi)  r_shadow_period[PERIOD_W-1:8] <= wr_data[PERIOD_W-9:0];
      if (w_wr_vol) r_volume                      <= wr_data[VOL_W-1:0];
    end
  end

  logic w_reload, w_clear_phase, w_decrement, w_toggle;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_reload      = 1'b0;
    w_clear_phase = 1'b0;
    w_decrement   = 1'b0;
    w_toggle      = 1'b0;
    case (r_state)
      PSG_IDLE: begin
        w_reload      = 1'b1;
        w_clear_phase = 1'b1;
        if (w_wr_ctrl && wr_data[PSG_CTRL_EN_BIT]) w_state_next = PSG_RUN;
      end
      PSG_RUN: begin
        if (w_wr_ctrl && !wr_data[PSG_CTRL_EN_BIT]) begin
          w_state_next  = PSG_IDLE;
          w_reload      = 1'b1;
          w_clear_phase = 1'b1;
        end else if (r_restart_pend) begin
          // Restart wins over a tick landing on the same edge.
          w_reload      = 1'b1;
          w_clear_phase = 1'b1;
        end else if (w_tick) begin
          if (r_counter == '0) begin
            w_reload = 1'b1;
            w_toggle = 1'b1;
          end else begin
            w_decrement = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= PSG_IDLE;
      r_counter       <= '0;
      r_active_period <= '0;
      r_phase         <= 1'b0;
      r_restart_pend  <= 1'b0;
      r_wrap          <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Reload reads the pre-edge shadow, so a write on a wrap edge waits
      // for the following wrap.
      if (w_reload) begin
        r_counter       <= r_shadow_period;
        r_active_period <= r_shadow_period;
      end else if (w_decrement) begin
        r_counter <= r_counter - PERIOD_W'(1);
      end
      if (w_clear_phase) begin
        r_phase <= 1'b0;
      end else if (w_toggle) begin
        r_phase <= ~r_phase;
      end
      r_wrap         <= w_toggle;
      r_restart_pend <= w_wr_ctrl && wr_data[PSG_CTRL_RESTART_BIT];
    end
  end

  a_counter_bounded: assert property (
    @(posedge clk) disable iff (!rst_n) r_counter <= r_active_period
  );

  assign tone_out = r_phase & ena;
  assign level    = tone_out ? r_volume : '0;
  assign wrap     = r_wrap & ena;

endmodule

// File: tb/tb_tt_um_accelshark_psg_tone.sv
// Directed scoreboard bench for the SharkPSG tone channel: per-cycle expected
// outputs are queued as stimulus is applied and popped at each falling edge.
module tb_tt_um_accelshark_psg_tone;
  import tt_um_accelshark_psg_pkg::*;

  typedef struct {
    logic       tone;
    logic [3:0] level;
    logic       wrap;
  } exp_t;

  logic       clk, rst_n, ena, clk_div, wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       tone_out, wrap;
  logic [3:0] level;

  int   n_compared = 0;
  int   n_mismatch = 0;
  exp_t sb_q[$];
  logic t;

  tt_um_accelshark_psg_tone #(.PERIOD_W(12), .VOL_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .clk_div  (clk_div),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .tone_out (tone_out),
    .level    (level),
    .wrap     (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divide-by-2 stage upstream of the channel; held high in reset.
  initial begin
    clk_div = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clk_div = rst_n ? ~clk_div : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wr(input logic [1:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
  endtask

  task automatic wr_idle();
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'd0;
  endtask

  // Queue n cycles of expected output (wrap only on the first if requested),
  // then pop and compare one entry per falling edge.
  task automatic expect_cycles(input string tag, input logic tone, input logic [3:0] vol,
                               input logic first_wrap, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tone  = tone;
      e.level = tone ? vol : 4'h0;
      e.wrap  = (i == 0) ? first_wrap : 1'b0;
      sb_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      check({tag, "_tone"},  {7'd0, tone_out}, {7'd0, e.tone});
      check({tag, "_level"}, {4'd0, level},    {4'd0, e.level});
      check({tag, "_wrap"},  {7'd0, wrap},     {7'd0, e.wrap});
    end
  endtask

  task automatic sync_wrap(input string tag, input int max_cycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) found = 1'b1;
    end
    check(tag, {7'd0, found}, 8'd1);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    ena   = 1'b1;
    wr_idle();
    #1;
    check("rst_tone", {7'd0, tone_out}, 8'd0);
    check("rst_level", {4'd0, level}, 8'd0);
    check("rst_wrap", {7'd0, wrap}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_cycles("idle", 1'b0, 4'h0, 1'b0, 4);

    // PERIOD = 3 (upper HI nibble ignored), VOLUME = 0xA (upper nibble ignored).
    drive_wr(PSG_ADDR_PERIOD_LO, 8'h03); expect_cycles("cfg", 1'b0, 4'h0, 1'b0, 1);
    drive_wr(PSG_ADDR_PERIOD_HI, 8'hF0); expect_cycles("cfg", 1'b0, 4'h0, 1'b0, 1);
    drive_wr(PSG_ADDR_VOLUME, 8'h5A);    expect_cycles("cfg", 1'b0, 4'h0, 1'b0, 1);
    drive_wr(PSG_ADDR_CTRL, 8'h01);      expect_cycles("cfg", 1'b0, 4'h0, 1'b0, 1);
    wr_idle();
    sync_wrap("p3_first_wrap", 40);
    check("p3_sync_tone", {7'd0, tone_out}, 8'd1);
    check("p3_sync_level", {4'd0, level}, 8'h0A);
    t = 1'b1;
    expect_cycles("p3", t, 4'hA, 1'b0, 7);
    for (int h = 0; h < 4; h++) begin
      t = ~t;
      expect_cycles("p3", t, 4'hA, 1'b1, 8);
    end

    // Period change mid half-period: current half keeps 8 clk, later halves 16.
    t = ~t;
    expect_cycles("p7_cur", t, 4'hA, 1'b1, 3);
    drive_wr(PSG_ADDR_PERIOD_LO, 8'h07);
    expect_cycles("p7_cur", t, 4'hA, 1'b0, 1);
    wr_idle();
    expect_cycles("p7_cur", t, 4'hA, 1'b0, 4);
    t = ~t; expect_cycles("p7", t, 4'hA, 1'b1, 16);
    t = ~t; expect_cycles("p7", t, 4'hA, 1'b1, 16);

    // Write landing on the wrap edge: old shadow (7) reloads, new value (1) next.
    drive_wr(PSG_ADDR_PERIOD_LO, 8'h01);
    t = ~t; expect_cycles("wrap_wr", t, 4'hA, 1'b1, 1);
    wr_idle();
    expect_cycles("wrap_wr", t, 4'hA, 1'b0, 15);
    t = ~t; expect_cycles("p1", t, 4'hA, 1'b1, 4);

    // PERIOD = 0: toggle every tick.
    t = ~t;
    expect_cycles("p1", t, 4'hA, 1'b1, 1);
    drive_wr(PSG_ADDR_PERIOD_LO, 8'h00);
    expect_cycles("p1", t, 4'hA, 1'b0, 1);
    wr_idle();
    expect_cycles("p1", t, 4'hA, 1'b0, 2);
    for (int h = 0; h < 4; h++) begin
      t = ~t;
      expect_cycles("p0", t, 4'hA, 1'b1, 2);
    end
    if (t == 1'b1) begin
      t = ~t;
      expect_cycles("p0", t, 4'hA, 1'b1, 2);
    end

    // Volume change while high acts the next cycle.
    t = ~t;
    expect_cycles("vol", t, 4'hA, 1'b1, 1);
    drive_wr(PSG_ADDR_VOLUME, 8'h0F);
    expect_cycles("vol", t, 4'hF, 1'b0, 1);
    wr_idle();

    // Switch to PERIOD = 4 (10 clk halves).
    t = ~t;
    expect_cycles("p4_sw", t, 4'hF, 1'b1, 1);
    drive_wr(PSG_ADDR_PERIOD_LO, 8'h04);
    expect_cycles("p4_sw", t, 4'hF, 1'b0, 1);
    wr_idle();

    // Restart while phase = 1: phase clears, then 5 ticks to the first toggle.
    t = ~t;
    expect_cycles("rs_pre", t, 4'hF, 1'b1, 1);
    expect_cycles("rs_pre", t, 4'hF, 1'b0, 3);
    drive_wr(PSG_ADDR_CTRL, 8'h03);
    expect_cycles("rs_pend", t, 4'hF, 1'b0, 1);
    wr_idle();
    expect_cycles("rs_low", 1'b0, 4'hF, 1'b0, 9);
    t = 1'b1; expect_cycles("rs_post", t, 4'hF, 1'b1, 10);
    t = ~t;   expect_cycles("rs_post", t, 4'hF, 1'b1, 10);

    // ena low for 10 clk mid-count: outputs zero, counter frozen.
    t = ~t;
    expect_cycles("ena_pre", t, 4'hF, 1'b1, 1);
    expect_cycles("ena_pre", t, 4'hF, 1'b0, 3);
    ena = 1'b0;
    expect_cycles("ena_off", 1'b0, 4'hF, 1'b0, 10);
    ena = 1'b1;
    expect_cycles("ena_resume", t, 4'hF, 1'b0, 6);
    t = ~t; expect_cycles("ena_next", t, 4'hF, 1'b1, 10);

    // CTRL enable cleared: phase drops on the write edge and stays idle.
    t = ~t;
    expect_cycles("stop_pre", t, 4'hF, 1'b1, 2);
    drive_wr(PSG_ADDR_CTRL, 8'h00);
    expect_cycles("stop_edge", 1'b0, 4'hF, 1'b0, 1);
    wr_idle();
    expect_cycles("stop_idle", 1'b0, 4'hF, 1'b0, 20);
    drive_wr(PSG_ADDR_CTRL, 8'h01);
    expect_cycles("reen", 1'b0, 4'hF, 1'b0, 1);
    wr_idle();
    sync_wrap("reen_wrap", 40);
    check("reen_tone", {7'd0, tone_out}, 8'd1);
    check("reen_level", {4'd0, level}, 8'h0F);
    expect_cycles("reen", 1'b1, 4'hF, 1'b0, 3);

    // Asynchronous reset mid-RUN between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    e.tone = 1'b0; e.level = 4'h0; e.wrap = 1'b0;
    sb_q.push_back(e);
    e = sb_q.pop_front();
    check("arst_tone", {7'd0, tone_out}, {7'd0, e.tone});
    check("arst_level", {4'd0, level}, {4'd0, e.level});
    check("arst_wrap", {7'd0, wrap}, {7'd0, e.wrap});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_cycles("post_rst", 1'b0, 4'h0, 1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/tt_um_accelshark_psg_tone.md
Name: tt_um_accelshark_psg_tone

Overview:
Single square-wave tone channel of the SharkPSG. It sits directly downstream of the divide-by-2 clock stage and consumes its half-rate `clk_div` output. It does not clock from `clk_div`: it detects the rising edge of `clk_div` in the `clk` domain and uses the result as a tick enable. Period and volume come from a small byte-wide register file, and period changes are double-buffered so they apply glitch-free at a waveform edge.

Parameters:
PERIOD_W, 12, width of the tone period register and down-counter
VOL_W, 4, width of the volume register and level output

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low, ticks are ignored and outputs are forced to 0
clk_div  input  1  half-rate toggle from the divider stage; resets high
wr_en  input  1  single-cycle register write strobe; always accepted
wr_addr  input  2  register select: 0 = PERIOD_LO, 1 = PERIOD_HI, 2 = VOLUME, 3 = CTRL
wr_data  input  8  write data
tone_out  output  1  square-wave phase
level  output  VOL_W  amplitude: volume when tone_out is 1, otherwise 0
wrap  output  1  one-cycle pulse on each phase toggle

Behaviour:
- Reset is asynchronous and active-low; the clock is `clk`, the single clock. Reset values:
  - `clk_div_q` = 1, so the first tick follows the divider's first high transition.
  - `shadow_period` = 0 and `active_period` = 0.
  - `counter` = 0, `phase` = 0, `volume` = 0.
  - `ctrl_en` = 0, `restart_pend` = 0.
  - Outputs `tone_out`, `level` and `wrap` are all 0.
- Tick: `tick = ena & clk_div & ~clk_div_q`. `clk_div_q` registers `clk_div` every clk. With the divider running, this gives one tick per 2 clk.
- Register writes:
  - Addr 0 writes `shadow_period[7:0]`.
  - Addr 1 writes `shadow_period[11:8]` from `wr_data[3:0]`; the upper bits of `wr_data` are ignored.
  - Addr 2 writes `volume` from `wr_data[3:0]`.
  - Addr 3: bit0 writes `ctrl_en`; bit1 = 1 sets `restart_pend`. Bit1 is self-clearing and reads as a pulse only.
  - Writes take effect on the clk edge on which `wr_en` is sampled.
- State machine, two states:
  - IDLE (`ctrl_en` = 0):
    - `counter` <= `shadow_period`, `active_period` <= `shadow_period`, `phase` <= 0, `restart_pend` <= 0.
    - Ticks are ignored.
    - Leaves for RUN on the cycle after `ctrl_en` is written to 1.
  - RUN (`ctrl_en` = 1), on each tick:
    - If `counter` != 0: `counter` decrements by 1.
    - If `counter` == 0: `phase` toggles, `counter` <= `shadow_period`, `active_period` <= `shadow_period`, and `wrap` pulses for 1 clk.
    - Each half-period therefore lasts (P+1) ticks = 2(P+1) clk. P = 0 toggles every tick.
  - RUN exits to IDLE on the clk edge that writes `ctrl_en` = 0. `phase` clears on that same edge.
- Restart (`restart_pend` = 1 while in RUN):
  - On the next clk, whether or not a tick occurs: `counter` <= `shadow_period`, `active_period` <= `shadow_period`, `phase` <= 0, `restart_pend` <= 0, `wrap` = 0.
  - Restart has priority over a simultaneous tick.
- Write coinciding with a wrap: the reload uses the shadow value held before the write. The new value lands in the shadow and applies at the following wrap.
- `ena` low: ticks are suppressed and the counter freezes. `tone_out` and `level` are forced to 0 combinationally. Register writes still land.
- Outputs:
  - `tone_out` = `phase & ena`.
  - `level` = `tone_out ? volume : 0`.
  - Volume changes act immediately; there is no double-buffering on volume.
- Width rule: `counter` is PERIOD_W bits and never wraps below 0, because reload happens at 0.
- Reset mid-operation: everything returns to reset values immediately, asynchronously.

Decomposition:
- Package `tt_um_accelshark_psg_pkg` holds:
  - Register address constants `PSG_ADDR_PERIOD_LO`, `PSG_ADDR_PERIOD_HI`, `PSG_ADDR_VOLUME`, `PSG_ADDR_CTRL`.
  - `PSG_CTRL_EN_BIT` = 0 and `PSG_CTRL_RESTART_BIT` = 1.
  - Default widths `PSG_PERIOD_W` = 12 and `PSG_VOL_W` = 4.
- Sub-module `tt_um_accelshark_psg_tick` is the edge detector (`clk_div`, `ena` -> `tick`). It will be reused by the noise and envelope channels.

Test Plan:
- Reset, then write PERIOD = 3 and VOLUME = 0xA, then CTRL = 0x01, with `ena` = 1 and the divider running -> `tone_out` toggles every 8 clk (16-clk period). `level` alternates 0xA / 0; `wrap` pulses once per toggle.
- While running at PERIOD = 3, write PERIOD_LO = 7 mid half-period -> the current half-period still lasts 8 clk; subsequent half-periods last 16 clk; no runt pulse.
- PERIOD = 0 -> `tone_out` toggles on every tick (every 2 clk). Write VOLUME = 0xF while high -> `level` = 0xF the next cycle.
- Write CTRL = 0x03 while `phase` = 1 -> the next cycle gives `phase` = 0 and `counter` = shadow; the first toggle follows after (P+1) ticks.
- Drop `ena` for 10 clk mid-count -> `tone_out` and `level` = 0 and the counter is frozen. Raise `ena` -> counting resumes from the frozen value.
- Assert `rst_n` = 0 asynchronously mid-RUN -> all outputs are 0 immediately. After release with CTRL unwritten -> the block stays in IDLE and `level` stays 0.
